uart_tx_shifter: RTL
====================

// Module: uart_tx_shifter
// PURPOSE
//  - Parametrised UART transmit serialiser; next generation of the UART PISO stage.
//  - Accepts a parallel word via a valid/ready handshake and emits a full frame:
//    start, 5..MAX_DATA_W data bits, optional odd/even parity, 1 or 2 stop bits.
//  - Bits advance on a baud_tick enable inside a single clock domain; no baud-derived clock.
//  - Sits between the UART register/FIFO front end and the TX pad.
// PARAMETERS
//  MAX_DATA_W  8  widest data field supported (5..16); sets data_in width
//  MSB_FIRST   0  0: data sent LSB first (UART standard); 1: MSB first
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            reset, asynchronous, active-low
//  baud_tick    in   1            one-clk enable per bit period
//  data_in      in   MAX_DATA_W   word to send; unused upper bits ignored
//  send         in   1            valid; word taken when send && ready at a clk edge
//  ready        out  1            block can take a word this cycle
//  data_length  in   4            data bits per frame, 5..MAX_DATA_W
//  parity_type  in   2            00/11 none, 01 odd, 10 even
//  stop_bits    in   1            0: one stop bit; 1: two stop bits
//  data_out     out  1            serial line; idles high
//  tx_active    out  1            high from acceptance to end of last stop bit
//  tx_done      out  1            one-clk pulse at end of last stop bit
//  p_parity_out out  1            high when the latched frame has no parity bit
// BEHAVIOUR
//  - Reset (async, any state): data_out=1, ready=1, tx_active=0, tx_done=0,
//    p_parity_out=1, FSM=IDLE, counters 0. A frame in progress is discarded.
//  - data_in, data_length, parity_type, stop_bits sampled only at acceptance.
//    Mid-frame input changes have no effect.
//  - data_length outside 5..MAX_DATA_W is clamped to MAX_DATA_W.
//  - FSM: IDLE -> WAIT -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
//  - IDLE: on acceptance go to WAIT and set tx_active=1, ready=0.
//  - WAIT: on the next baud_tick, data_out=0 and go to START.
//    A baud_tick in the acceptance cycle itself is ignored.
//  - State, data_out and bit-counter updates happen only on clk edges with baud_tick=1.
//    Each bit is held for exactly one tick interval.
//  - DATA: shift out data_length bits in MSB_FIRST order; 4-bit counter counts 0..len-1.
//  - PARITY: odd = ~^data, even = ^data, over the data_length bits only.
//  - STOP1/STOP2: data_out=1.
//  - On the tick that ends the last stop bit: tx_done=1 for one clk, tx_active=0, FSM=IDLE.
//  - ready: in the base build, high only in IDLE. send while ready=0 is ignored (no queuing).
//  - Latency: acceptance to start-bit edge is <= 1 tick period + 1 clk.
//    Frame = 1 + len + P + S tick periods.
//  - baud_tick held high continuously is legal: one bit per clk.
// CONFIGURATION
//  UART_TX_HOLD_EN
//  - Defined: adds a one-entry holding register (word plus config).
//    ready = hold empty, so a word can be accepted while a frame is shifting.
//    At STOP end, if hold is full, go directly to START (data_out=0 on that same tick);
//    no idle gap between frames. tx_done still pulses; tx_active stays high.
//    Hold is cleared by reset.
//  - Undefined: no holding register; ready low for the whole frame.
//    At least one idle tick between frames.
// TESTING
//  - Reset: pulse rst_n low mid-frame -> data_out=1, tx_active=0, ready=1 within
//    the same cycle, before any clk edge.
//  - 8N1, tick every 16 clk: data_in=8'hA5, parity_type=00 -> line 0,1,0,1,0,0,1,0,1,1
//    (LSB first); tx_done one clk at tick 10; p_parity_out=1.
//  - 7E2: data_in=8'h41, data_length=7, parity_type=10, stop_bits=1 ->
//    start, 1000001 (LSB first), parity 0, two stop bits; 11 tick periods total.
//  - 8O1 with MSB_FIRST=1: data_in=8'h80 -> start, 1, then 0 x7, parity 0, stop.
//    Change parity_type mid-frame -> frame unchanged.
//  - Handshake: send held high for 3 words with UART_TX_HOLD_EN undefined ->
//    one idle tick between frames; ready=0 throughout each frame.
//  - UART_TX_HOLD_EN defined: 2nd word accepted during frame 1 -> start bit on the
//    tick after frame-1 stop; tx_active never drops between frames.
//    data_length=15 on an 8-bit build -> 8 data bits sent.

Source files
------------

// File: rtl/uart_tx_shifter.sv
// UART transmit serialiser: start, 5..MAX_DATA_W data bits, optional parity, 1-2 stop bits.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_shifter #(
    parameter int MAX_DATA_W = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic [MAX_DATA_W-1:0] data_in,
    input  logic                  send,
    output logic                  ready,
    input  logic [3:0]            data_length,
    input  logic [1:0]            parity_type,
    input  logic                  stop_bits,
    output logic                  data_out,
    output logic                  tx_active,
    output logic                  tx_done,
    output logic                  p_parity_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP1  = 3'd5;
    localparam logic [2:0] S_STOP2  = 3'd6;

    localparam logic [4:0] MAX_LEN = 5'(MAX_DATA_W);

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [4:0]            len;
        logic [1:0]            par;
        logic                  stop2;
    } frame_t;

    function automatic logic [4:0] clamp_len(input logic [3:0] l);
        if (l < 4'd5 || {1'b0, l} > MAX_LEN)
            return MAX_LEN;
        return {1'b0, l};
    endfunction

    function automatic logic has_parity(input logic [1:0] p);
        return (p == 2'b01) || (p == 2'b10);
    endfunction

    frame_t                in_frame;
    frame_t                cur;
    logic [2:0]            state;
    logic [3:0]            cnt;
    logic                  accept;
    logic                  frame_end;
    logic                  last_bit;
    logic                  px;
    logic                  par_bit;
    logic                  nxt_bit;
    logic [4:0]            nxt_k;
    logic [4:0]            nxt_idx;
    logic [MAX_DATA_W-1:0] shifted;

    always_comb begin
        in_frame.data  = data_in;
        in_frame.len   = clamp_len(data_length);
        in_frame.par   = parity_type;
        in_frame.stop2 = stop_bits;
    end

    assign frame_end = baud_tick &&
                       ((state == S_STOP1 && !cur.stop2) || state == S_STOP2);
    assign last_bit  = ({1'b0, cnt} == cur.len - 5'd1);

    // Parity covers only the active data_length bits; the next data bit is picked by index
    // so MSB-first frames of any length need no pre-alignment.
    always_comb begin
        px = 1'b0;
        for (int i = 0; i < MAX_DATA_W; i++)
            if (5'(i) < cur.len)
                px = px ^ cur.data[i];
        par_bit = (cur.par == 2'b01) ? ~px : px;
        nxt_k   = (state == S_START) ? 5'd0 : {1'b0, cnt} + 5'd1;
        nxt_idx = MSB_FIRST ? (cur.len - 5'd1 - nxt_k) : nxt_k;
        shifted = cur.data >> nxt_idx;
        nxt_bit = shifted[0];
    end

`ifdef UART_TX_HOLD_EN
    frame_t hold;
    logic   hold_full;

    assign ready = ~hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (hold_full && frame_end) begin
            hold_full <= 1'b0;
        end else if (accept && state != S_IDLE && !frame_end) begin
            hold      <= in_frame;
            hold_full <= 1'b1;
        end
    end
`else
    assign ready = (state == S_IDLE);
`endif

    assign accept = send && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cur          <= '0;
            cnt          <= '0;
            data_out     <= 1'b1;
            tx_active    <= 1'b0;
            tx_done      <= 1'b0;
            p_parity_out <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    cur          <= in_frame;
                    p_parity_out <= ~has_parity(parity_type);
                    tx_active    <= 1'b1;
                    state        <= S_WAIT;
                end
                S_WAIT: if (baud_tick) begin
                    data_out <= 1'b0;
                    state    <= S_START;
                end
                S_START: if (baud_tick) begin
                    data_out <= nxt_bit;
                    cnt      <= '0;
                    state    <= S_DATA;
                end
                S_DATA: if (baud_tick) begin
                    if (last_bit) begin
                        if (has_parity(cur.par)) begin
                            data_out <= par_bit;
                            state    <= S_PARITY;
                        end else begin
                            data_out <= 1'b1;
                            state    <= S_STOP1;
                        end
                    end else begin
                        cnt      <= cnt + 4'd1;
                        data_out <= nxt_bit;
                    end
                end
                S_PARITY: if (baud_tick) begin
                    data_out <= 1'b1;
                    state    <= S_STOP1;
                end
                S_STOP1: if (baud_tick && cur.stop2) state <= S_STOP2;
                S_STOP2: ;
                default: state <= S_IDLE;
            endcase

            // End of the last stop bit overrides whatever the case above chose.
            if (frame_end) begin
                tx_done <= 1'b1;
`ifdef UART_TX_HOLD_EN
                if (hold_full) begin
                    cur          <= hold;
                    p_parity_out <= ~has_parity(hold.par);
                    data_out     <= 1'b0;
                    state        <= S_START;
                end else if (accept) begin
                    cur          <= in_frame;
                    p_parity_out <= ~has_parity(parity_type);
                    state        <= S_WAIT;
                end else begin
                    tx_active <= 1'b0;
                    state     <= S_IDLE;
                end
`else
                tx_active <= 1'b0;
                state     <= S_IDLE;
`endif
            end
        end
    end

endmodule
